// File: rtl/iob_acc_seq.sv
// Purpose : sequences load/enable/increment of a downstream accumulator through a 2-level nested address/value pattern.
// Latency : start_i to first valid_o is 2 cycles (IDLE->LOAD->RUN); acc_* controls are combinational, no latency.
// Backpr. : valid_o holds while ready_i=0 and the accumulator is not stepped; cke_i=0 freezes all state.
//
// Ports: clk_i/rst_i (sync active-high), cke_i clock enable, start_i start pulse (IDLE only),
//        base_i/stride_i/shift_i/iter_i/per_i pattern config (latched at start),
//        ready_i consumer accept, valid_o/busy_o/done_o registered status,
//        acc_ld_o/acc_ld_val_o/acc_en_o/acc_incr_o accumulator controls.
module iob_acc_seq #(
    parameter int DATA_W = 21,
    parameter int CNT_W  = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              cke_i,
    input  logic              start_i,
    input  logic [DATA_W-1:0] base_i,
    input  logic [DATA_W-1:0] stride_i,
    input  logic [DATA_W-1:0] shift_i,
    input  logic [CNT_W-1:0]  iter_i,
    input  logic [CNT_W-1:0]  per_i,
    input  logic              ready_i,
    output logic              valid_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              acc_ld_o,
    output logic [DATA_W-1:0] acc_ld_val_o,
    output logic              acc_en_o,
    output logic [DATA_W-1:0] acc_incr_o
);

    typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

    state_t            state;
    logic [DATA_W-1:0] base_r;
    logic [DATA_W-1:0] stride_r;
    logic [DATA_W-1:0] shift_r;
    logic [CNT_W-1:0]  iter_r;
    logic [CNT_W-1:0]  per_r;
    logic [CNT_W-1:0]  i_cnt;
    logic [CNT_W-1:0]  j_cnt;

    logic i_last;
    logic j_last;
    logic hs;

    // iter_r/per_r are never 0 while in RUN, so the -1 compare cannot wrap.
    assign i_last = (i_cnt == iter_r - CNT_W'(1));
    assign j_last = (j_cnt == per_r - CNT_W'(1));
    assign hs     = (state == RUN) && ready_i && cke_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state    <= IDLE;
            base_r   <= '0;
            stride_r <= '0;
            shift_r  <= '0;
            iter_r   <= '0;
            per_r    <= '0;
            i_cnt    <= '0;
            j_cnt    <= '0;
            valid_o  <= 1'b0;
            busy_o   <= 1'b0;
            done_o   <= 1'b0;
        end else if (cke_i) begin
            case (state)
                IDLE: begin
                    if (start_i) begin
                        base_r   <= base_i;
                        stride_r <= stride_i;
                        shift_r  <= shift_i;
                        iter_r   <= iter_i;
                        per_r    <= per_i;
                        // An empty pattern skips straight to completion.
                        if (iter_i == '0 || per_i == '0) begin
                            state  <= DONE;
                            done_o <= 1'b1;
                        end else begin
                            state  <= LOAD;
                            busy_o <= 1'b1;
                        end
                    end
                end
                LOAD: begin
                    i_cnt   <= '0;
                    j_cnt   <= '0;
                    state   <= RUN;
                    valid_o <= 1'b1;
                end
                RUN: begin
                    if (hs) begin
                        if (i_last && j_last) begin
                            state   <= DONE;
                            valid_o <= 1'b0;
                            busy_o  <= 1'b0;
                            done_o  <= 1'b1;
                        end else if (i_last) begin
                            i_cnt <= '0;
                            j_cnt <= j_cnt + CNT_W'(1);
                        end else begin
                            i_cnt <= i_cnt + CNT_W'(1);
                        end
                    end
                end
                DONE: begin
                    state  <= IDLE;
                    done_o <= 1'b0;
                end
                default: begin
                    state   <= IDLE;
                    valid_o <= 1'b0;
                    busy_o  <= 1'b0;
                    done_o  <= 1'b0;
                end
            endcase
        end
    end

    // Accumulator controls: the final handshake does not step the accumulator,
    // and the inner-loop wrap uses shift instead of stride.
    always_comb begin
        acc_ld_o     = 1'b0;
        acc_en_o     = 1'b0;
        acc_ld_val_o = '0;
        acc_incr_o   = '0;
        if (cke_i && state == LOAD) begin
            acc_ld_o     = 1'b1;
            acc_en_o     = 1'b1;
            acc_ld_val_o = base_r;
        end else if (hs && !(i_last && j_last)) begin
            acc_en_o   = 1'b1;
            acc_incr_o = i_last ? shift_r : stride_r;
        end
    end

endmodule

// File: tb/tb_iob_acc_seq.sv
// Purpose : self-checking bench for iob_acc_seq with a downstream accumulator model and value scoreboard.
// Latency : checks start->first valid of 2 cycles and done one cycle after the last handshake.
// Backpr. : exercises ready_i stalls, cke_i freezes and mid-sequence reset.
module tb_iob_acc_seq;

    localparam int DATA_W = 21;
    localparam int CNT_W  = 16;

    logic              clk_i = 1'b0;
    logic              rst_i = 1'b1;
    logic              cke_i = 1'b1;
    logic              start_i = 1'b0;
    logic [DATA_W-1:0] base_i = '0;
    logic [DATA_W-1:0] stride_i = '0;
    logic [DATA_W-1:0] shift_i = '0;
    logic [CNT_W-1:0]  iter_i = '0;
    logic [CNT_W-1:0]  per_i = '0;
    logic              ready_i = 1'b0;
    logic              valid_o;
    logic              busy_o;
    logic              done_o;
    logic              acc_ld_o;
    logic [DATA_W-1:0] acc_ld_val_o;
    logic              acc_en_o;
    logic [DATA_W-1:0] acc_incr_o;

    iob_acc_seq #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .cke_i        (cke_i),
        .start_i      (start_i),
        .base_i       (base_i),
        .stride_i     (stride_i),
        .shift_i      (shift_i),
        .iter_i       (iter_i),
        .per_i        (per_i),
        .ready_i      (ready_i),
        .valid_o      (valid_o),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .acc_ld_o     (acc_ld_o),
        .acc_ld_val_o (acc_ld_val_o),
        .acc_en_o     (acc_en_o),
        .acc_incr_o   (acc_incr_o)
    );

    always #5 clk_i = ~clk_i;

    // Downstream load-capable accumulator driven by the DUT controls.
    logic [DATA_W-1:0] acc_m = '0;
    always @(posedge clk_i) begin
        if (acc_ld_o)
            acc_m <= acc_ld_val_o;
        else if (acc_en_o)
            acc_m <= acc_m + acc_incr_o;
    end

    int n_vec = 0;
    int n_bad = 0;
    logic [DATA_W-1:0] exp_q[$];

    int step_n, busy_cnt, ld_cnt, en_cnt, hs_cnt, first_valid, last_hs, done_step, done_cnt;

    task automatic chk(input string tag, input int obs, input int exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (step %0d)", tag, obs, exp, step_n);
        end
    endtask

    task automatic clr_stats();
        step_n = -1; busy_cnt = 0; ld_cnt = 0; en_cnt = 0; hs_cnt = 0;
        first_valid = -1; last_hs = -1; done_step = -1; done_cnt = 0;
    endtask

    // Samples DUT outputs at the falling edge, in the middle of the cycle.
    task automatic mon();
        step_n++;
        if (busy_o) busy_cnt++;
        if (acc_ld_o) ld_cnt++;
        if (acc_en_o) en_cnt++;
        if (!cke_i) begin
            chk("cke_en", int'(acc_en_o), 0);
            chk("cke_ld", int'(acc_ld_o), 0);
        end
        if (valid_o && first_valid < 0) first_valid = step_n;
        if (valid_o && ready_i && cke_i) begin
            hs_cnt++;
            last_hs = step_n;
            if (exp_q.size() == 0)
                chk("extra_elem", 1, 0);
            else
                chk("acc_val", int'(acc_m), int'(exp_q.pop_front()));
        end else if (valid_o) begin
            chk("stall_en", int'(acc_en_o), 0);
        end
        if (done_o) begin
            done_cnt++;
            done_step = step_n;
        end
    endtask

    task automatic step();
        @(negedge clk_i);
        mon();
        @(posedge clk_i);
        #1;
    endtask

    task automatic push_exp(input logic [DATA_W-1:0] b, s, sh, input int it, pe);
        logic [DATA_W-1:0] wrap_inc;
        wrap_inc = sh + DATA_W'(it - 1) * s;
        for (int j = 0; j < pe; j++)
            for (int i = 0; i < it; i++)
                exp_q.push_back(b + DATA_W'(i) * s + DATA_W'(j) * wrap_inc);
    endtask

    // mode 0: ready always 1; 1: ready 1,0,0 repeating; 2: cke stall with start pulses.
    task automatic run(input logic [DATA_W-1:0] b, s, sh, input int it, pe, input int mode);
        int nx;
        bit degen;
        degen = (it == 0) || (pe == 0);
        clr_stats();
        exp_q.delete();
        push_exp(b, s, sh, it, pe);
        base_i = b; stride_i = s; shift_i = sh;
        iter_i = CNT_W'(it); per_i = CNT_W'(pe);
        start_i = 1'b1; ready_i = 1'b1; cke_i = 1'b1;
        step();
        start_i = 1'b0;
        // Config changes after the start must not affect the running sequence.
        base_i = 21'h0ABCDE; stride_i = 21'h333; shift_i = 21'h777;
        iter_i = 16'd9; per_i = 16'd9;
        while (done_step < 0 && step_n < 3000) begin
            nx = step_n + 1;
            ready_i = (mode == 1) ? (nx % 3 == 2) : 1'b1;
            cke_i   = !(mode == 2 && nx >= 4 && nx <= 6);
            start_i = (mode == 2 && nx >= 4 && nx <= 7) ||
                      (mode == 0 && !degen && nx == it * pe + 2);
            step();
        end
        start_i = 1'b0; cke_i = 1'b1;
        chk("done_seen", done_cnt, 1);
        chk("hs_count", hs_cnt, it * pe);
        chk("q_empty", exp_q.size(), 0);
        if (degen) begin
            chk("degen_done_lat", done_step, 1);
            chk("degen_valid", first_valid, -1);
            chk("degen_ld", ld_cnt, 0);
            chk("degen_en", en_cnt, 0);
        end else begin
            chk("first_valid", first_valid, 2);
            chk("done_after_last", done_step, last_hs + 1);
            chk("ld_count", ld_cnt, 1);
            chk("en_count", en_cnt, it * pe);
            if (mode == 0) chk("busy_cycles", busy_cnt, 1 + it * pe);
        end
        step();
        chk("post_done", int'(done_o), 0);
        chk("post_busy", int'(busy_o), 0);
        chk("post_ld", int'(acc_ld_o), 0);
    endtask

    initial begin
        clr_stats();
        rst_i = 1'b1;
        repeat (3) step();
        chk("rst_valid", int'(valid_o), 0);
        chk("rst_busy", int'(busy_o), 0);
        chk("rst_done", int'(done_o), 0);
        chk("rst_ld", int'(acc_ld_o), 0);
        chk("rst_en", int'(acc_en_o), 0);
        rst_i = 1'b0;
        step();

        run(21'h100, 21'h4, 21'h40, 3, 2, 0);
        run(21'h100, 21'h4, 21'h40, 3, 2, 1);
        run(21'h100, 21'h4, 21'h40, 0, 5, 0);
        run(21'h100, 21'h4, 21'h40, 4, 0, 0);
        run(21'h1FFFF0, 21'h10, 21'h0, 2, 1, 0);
        run(21'h100, 21'h4, 21'h40, 3, 2, 2);
        run(21'h1F0000, 21'h1234, 21'h0F0F0, 4, 3, 1);

        // Reset in RUN after two handshakes.
        clr_stats();
        exp_q.delete();
        push_exp(21'h100, 21'h4, 21'h40, 3, 2);
        base_i = 21'h100; stride_i = 21'h4; shift_i = 21'h40; iter_i = 16'd3; per_i = 16'd2;
        start_i = 1'b1; ready_i = 1'b1;
        step();
        start_i = 1'b0;
        while (hs_cnt < 2 && step_n < 50) step();
        chk("rst_pre_hs", hs_cnt, 2);
        rst_i = 1'b1;
        step();
        rst_i = 1'b0;
        step();
        chk("mid_rst_valid", int'(valid_o), 0);
        chk("mid_rst_busy", int'(busy_o), 0);
        chk("mid_rst_ld", int'(acc_ld_o), 0);
        chk("mid_rst_en", int'(acc_en_o), 0);
        chk("mid_rst_incr", int'(acc_incr_o), 0);
        chk("mid_rst_ldval", int'(acc_ld_val_o), 0);
        repeat (2) step();
        chk("mid_rst_no_done", done_cnt, 0);

        run(21'h055, 21'h4, 21'h40, 1, 1, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
